multicycle_controller: RTL and testbench

//  Main-FSM plus ALU-decoder control unit for the multicycle RV32 core. It sits directly

---
 rtl/multicycle_controller_if.sv | 31 +++
 rtl/multicycle_controller.sv | 140 ++++++++++++++
 tb/tb_multicycle_controller.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the RV32 datapath.
// Instruction fields and Zero flow in; mux selects and write enables flow out.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_o;

    modport master (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ImmSrc, ALUControl, state_o
    );

    modport slave (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ImmSrc, ALUControl, state_o
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main FSM plus ALU decoder for the multicycle RV32 core (lw, sw, R, I-ALU, beq, jal).
// Moore outputs per state; PCWrite additionally depends on Zero during BEQ.
module multicycle_controller (
    input  logic                          clk,
    input  logic                          reset,
    multicycle_controller_if.master       ctl
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] alu_op;
    logic       pc_update, branch;
    logic       ir_write, mem_write, reg_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (ctl.op)
                    7'b0000011, 7'b0100011: state_d = MEMADR;
                    7'b0110011:             state_d = EXECR;
                    7'b0010011:             state_d = EXECI;
                    7'b1100011:             state_d = BEQ;
                    7'b1101111:             state_d = JAL;
                    default:                state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = ctl.op[5] ? MEMWRITE : MEMREAD;
            MEMREAD: state_d = MEMWB;
            EXECR, EXECI, JAL: state_d = ALUWB;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        ctl.AdrSrc    = 1'b0;
        ctl.ResultSrc = 2'b00;
        ctl.ALUSrcA   = 2'b00;
        ctl.ALUSrcB   = 2'b00;
        alu_op        = 2'b00;
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        case (state_q)
            FETCH: begin
                ir_write      = 1'b1;
                ctl.ALUSrcB   = 2'b10;
                ctl.ResultSrc = 2'b10;
                pc_update     = 1'b1;
            end
            DECODE: begin
                ctl.ALUSrcA = 2'b01;
                ctl.ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ctl.ALUSrcA = 2'b10;
                ctl.ALUSrcB = 2'b01;
            end
            MEMREAD:  ctl.AdrSrc = 1'b1;
            MEMWB: begin
                ctl.ResultSrc = 2'b01;
                reg_write     = 1'b1;
            end
            MEMWRITE: begin
                ctl.AdrSrc = 1'b1;
                mem_write  = 1'b1;
            end
            EXECR: begin
                ctl.ALUSrcA = 2'b10;
                alu_op      = 2'b10;
            end
            EXECI: begin
                ctl.ALUSrcA = 2'b10;
                ctl.ALUSrcB = 2'b01;
                alu_op      = 2'b10;
            end
            ALUWB:    reg_write = 1'b1;
            BEQ: begin
                ctl.ALUSrcA = 2'b10;
                alu_op      = 2'b01;
                branch      = 1'b1;
            end
            JAL: begin
                ctl.ALUSrcA = 2'b01;
                ctl.ALUSrcB = 2'b10;
                pc_update   = 1'b1;
            end
            default: ;
        endcase

        // Enables are gated by reset so nothing writes while the FSM is held in FETCH.
        ctl.IRWrite  = ir_write  & ~reset;
        ctl.MemWrite = mem_write & ~reset;
        ctl.RegWrite = reg_write & ~reset;
        ctl.PCWrite  = (pc_update | (branch & ctl.Zero)) & ~reset;
        ctl.state_o  = state_q;

        case (ctl.op)
            7'b0100011: ctl.ImmSrc = 2'b01;
            7'b1100011: ctl.ImmSrc = 2'b10;
            7'b1101111: ctl.ImmSrc = 2'b11;
            default:    ctl.ImmSrc = 2'b00;
        endcase

        case (alu_op)
            2'b01: ctl.ALUControl = 3'b001;
            2'b10: begin
                case (ctl.funct3)
                    3'b000:  ctl.ALUControl = (ctl.funct7b5 & ctl.op[5]) ? 3'b001 : 3'b000;
                    3'b001:  ctl.ALUControl = 3'b100;
                    3'b010:  ctl.ALUControl = 3'b101;
                    3'b110:  ctl.ALUControl = 3'b011;
                    3'b111:  ctl.ALUControl = 3'b010;
                    default: ctl.ALUControl = 3'b000;
                endcase
            end
            default: ctl.ALUControl = 3'b000;
        endcase
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class through its states.
`timescale 1ns/1ps
module tb_multicycle_controller;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.op = 7'b0000011;
        bus.funct3 = 3'b010;
        bus.funct7b5 = 1'b0;
        bus.Zero = 1'b0;
        #2;
        chk("rst_state", 8'(bus.state_o), 8'd0);
        chk("rst_irwrite", 8'(bus.IRWrite), 8'd0);
        chk("rst_pcwrite", 8'(bus.PCWrite), 8'd0);
        chk("rst_resultsrc", 8'(bus.ResultSrc), 8'd2);
        chk("rst_alusrcb", 8'(bus.ALUSrcB), 8'd2);
        step(); step();
        reset = 1'b0;
        #1;
        // T1 lw
        chk("lw_fetch_state", 8'(bus.state_o), 8'd0);
        chk("lw_fetch_irwrite", 8'(bus.IRWrite), 8'd1);
        chk("lw_fetch_pcwrite", 8'(bus.PCWrite), 8'd1);
        step();
        chk("lw_decode_state", 8'(bus.state_o), 8'd1);
        chk("lw_decode_srca", 8'(bus.ALUSrcA), 8'd1);
        chk("lw_decode_srcb", 8'(bus.ALUSrcB), 8'd1);
        chk("lw_immsrc", 8'(bus.ImmSrc), 8'd0);
        step();
        chk("lw_memadr_state", 8'(bus.state_o), 8'd2);
        chk("lw_memadr_srca", 8'(bus.ALUSrcA), 8'd2);
        step();
        chk("lw_memread_state", 8'(bus.state_o), 8'd3);
        chk("lw_memread_adrsrc", 8'(bus.AdrSrc), 8'd1);
        chk("lw_memread_regwrite", 8'(bus.RegWrite), 8'd0);
        step();
        chk("lw_memwb_state", 8'(bus.state_o), 8'd4);
        chk("lw_memwb_regwrite", 8'(bus.RegWrite), 8'd1);
        chk("lw_memwb_resultsrc", 8'(bus.ResultSrc), 8'd1);
        step();
        chk("lw_back_fetch", 8'(bus.state_o), 8'd0);
        // T2 R-type sub, then addi with funct7b5 set
        bus.op = 7'b0110011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b1;
        step(); step();
        chk("sub_execr_state", 8'(bus.state_o), 8'd6);
        chk("sub_alucontrol", 8'(bus.ALUControl), 8'd1);
        chk("sub_execr_srcb", 8'(bus.ALUSrcB), 8'd0);
        step();
        chk("sub_aluwb_state", 8'(bus.state_o), 8'd8);
        chk("sub_aluwb_regwrite", 8'(bus.RegWrite), 8'd1);
        chk("sub_aluwb_resultsrc", 8'(bus.ResultSrc), 8'd0);
        step();
        chk("sub_back_fetch", 8'(bus.state_o), 8'd0);
        bus.op = 7'b0010011;
        step(); step();
        chk("addi_execi_state", 8'(bus.state_o), 8'd7);
        chk("addi_alucontrol", 8'(bus.ALUControl), 8'd0);
        chk("addi_execi_srcb", 8'(bus.ALUSrcB), 8'd1);
        step(); step();
        chk("addi_back_fetch", 8'(bus.state_o), 8'd0);
        // T3 beq, Zero toggled inside the BEQ cycle
        bus.op = 7'b1100011; bus.Zero = 1'b0;
        step();
        chk("beq_immsrc", 8'(bus.ImmSrc), 8'd2);
        step();
        chk("beq_state", 8'(bus.state_o), 8'd9);
        chk("beq_alucontrol", 8'(bus.ALUControl), 8'd1);
        chk("beq_pcwrite_z0", 8'(bus.PCWrite), 8'd0);
        bus.Zero = 1'b1;
        #1;
        chk("beq_pcwrite_z1", 8'(bus.PCWrite), 8'd1);
        step();
        bus.Zero = 1'b0;
        chk("beq_back_fetch", 8'(bus.state_o), 8'd0);
        // T4 funct3 sweep inside one EXECR cycle
        bus.op = 7'b0110011; bus.funct7b5 = 1'b0; bus.funct3 = 3'b001;
        step(); step();
        chk("sweep_state", 8'(bus.state_o), 8'd6);
        chk("sweep_f3_001", 8'(bus.ALUControl), 8'd4);
        bus.funct3 = 3'b010; #1;
        chk("sweep_f3_010", 8'(bus.ALUControl), 8'd5);
        bus.funct3 = 3'b110; #1;
        chk("sweep_f3_110", 8'(bus.ALUControl), 8'd3);
        bus.funct3 = 3'b111; #1;
        chk("sweep_f3_111", 8'(bus.ALUControl), 8'd2);
        bus.funct3 = 3'b100; #0.5;
        chk("sweep_f3_100", 8'(bus.ALUControl), 8'd0);
        step(); step();
        chk("sweep_back_fetch", 8'(bus.state_o), 8'd0);
        // jal
        bus.op = 7'b1101111;
        step();
        chk("jal_immsrc", 8'(bus.ImmSrc), 8'd3);
        step();
        chk("jal_state", 8'(bus.state_o), 8'd10);
        chk("jal_pcwrite", 8'(bus.PCWrite), 8'd1);
        chk("jal_srca", 8'(bus.ALUSrcA), 8'd1);
        chk("jal_srcb", 8'(bus.ALUSrcB), 8'd2);
        step();
        chk("jal_aluwb_state", 8'(bus.state_o), 8'd8);
        step();
        // T5 unsupported op
        bus.op = 7'b1111111;
        chk("nop_fetch", 8'(bus.state_o), 8'd0);
        step();
        chk("nop_decode_state", 8'(bus.state_o), 8'd1);
        chk("nop_decode_pcwrite", 8'(bus.PCWrite), 8'd0);
        chk("nop_decode_regwrite", 8'(bus.RegWrite), 8'd0);
        chk("nop_decode_memwrite", 8'(bus.MemWrite), 8'd0);
        step();
        chk("nop_back_fetch", 8'(bus.state_o), 8'd0);
        chk("nop_fetch_memwrite", 8'(bus.MemWrite), 8'd0);
        // T6 sw interrupted by reset in MEMWRITE
        bus.op = 7'b0100011;
        step(); step(); step();
        chk("sw_memwrite_state", 8'(bus.state_o), 8'd5);
        chk("sw_memwrite_en", 8'(bus.MemWrite), 8'd1);
        chk("sw_immsrc", 8'(bus.ImmSrc), 8'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_state", 8'(bus.state_o), 8'd0);
        chk("rst_async_memwrite", 8'(bus.MemWrite), 8'd0);
        chk("rst_async_irwrite", 8'(bus.IRWrite), 8'd0);
        step();
        reset = 1'b0;
        #1;
        chk("post_rst_state", 8'(bus.state_o), 8'd0);
        chk("post_rst_irwrite", 8'(bus.IRWrite), 8'd1);
        step();
        chk("post_rst_decode", 8'(bus.state_o), 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
